// File: rtl/mole_hit_judge.sv
// Debounces three raw buttons and judges each press against the lit mole lines, keeping a saturating score.
// Press-to-output latency is 2 sync + DEBOUNCE_CYCLES + 1 cycles; there is no backpressure, and presses in IDLE/HELD are dropped.
module mole_hit_judge #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int SCORE_W         = 8
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               game,
    input  logic [2:0]         button,
    input  logic [2:0]         mole,
    output logic               turnoff,
    output logic [SCORE_W-1:0] score,
    output logic               hit,
    output logic               miss
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]   LP_CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] LP_SCORE_MAX = {SCORE_W{1'b1}};

    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_deb;
    logic [2:0]       r_deb_d;
    logic [CNT_W-1:0] r_cnt [3];

    state_t             r_state;
    logic [SCORE_W-1:0] r_score;
    logic               r_turnoff;
    logic               r_hit;
    logic               r_miss;

    logic [2:0]         w_press;
    logic               w_hit_match;
    logic               w_any_press;
    logic               w_mole_lit;
    state_t             w_nxt_state;
    logic [SCORE_W-1:0] w_nxt_score;
    logic               w_nxt_hit;
    logic               w_nxt_miss;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= button;
            r_sync2 <= r_sync1;
        end
    end

    // The counter only advances while the synced level disagrees with the accepted one,
    // so any return to the accepted level restarts the stability window.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_deb_d <= r_deb;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_CNT_LAST) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_press     = r_deb & ~r_deb_d;
    assign w_hit_match = |(w_press & mole);
    assign w_any_press = |w_press;
    assign w_mole_lit  = |mole;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_score   <= '0;
            r_turnoff <= 1'b0;
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_score   <= w_nxt_score;
            r_turnoff <= (w_nxt_state == ST_HELD);
            r_hit     <= w_nxt_hit;
            r_miss    <= w_nxt_miss;
        end
    end

    // A matching press takes priority over any unmatched bits pressed in the same cycle.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_score = r_score;
        w_nxt_hit   = 1'b0;
        w_nxt_miss  = 1'b0;
        if (!game) begin
            w_nxt_state = ST_IDLE;
            w_nxt_score = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt_score = '0;
                    w_nxt_state = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_hit_match) begin
                        w_nxt_hit   = 1'b1;
                        w_nxt_state = ST_HELD;
                        if (r_score != LP_SCORE_MAX) begin
                            w_nxt_score = r_score + SCORE_W'(1);
                        end
                    end else if (w_any_press && w_mole_lit) begin
                        w_nxt_miss = 1'b1;
                        if (r_score != '0) begin
                            w_nxt_score = r_score - SCORE_W'(1);
                        end
                    end
                end
                ST_HELD: begin
                    if (!w_mole_lit) begin
                        w_nxt_state = ST_ARMED;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_score = '0;
                end
            endcase
        end
    end

    assign turnoff = r_turnoff;
    assign score   = r_score;
    assign hit     = r_hit;
    assign miss    = r_miss;

endmodule

// File: tb/tb_mole_hit_judge.sv
// Table-driven bench for mole_hit_judge with a scoreboard queue plus hand-written corner sequences.
module tb_mole_hit_judge;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic       game   = 1'b0;
    logic [2:0] button = 3'b000;
    logic [2:0] mole   = 3'b000;
    logic       turnoff;
    logic [7:0] score;
    logic       hit;
    logic       miss;

    always #5 clock = ~clock;

    mole_hit_judge #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .SCORE_W        (8)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .game   (game),
        .button (button),
        .mole   (mole),
        .turnoff(turnoff),
        .score  (score),
        .hit    (hit),
        .miss   (miss)
    );

    typedef struct {
        string      name;
        logic [2:0] mole;
        logic [2:0] btn;
        logic [2:0] mole_after;
        int         hits;
        int         misses;
        int         score;
        int         to_hold;
        int         to_end;
    } vec_t;

    typedef struct {
        string name;
        int    hits;
        int    misses;
        int    score;
        int    to_hold;
        int    to_end;
    } exp_t;

    exp_t exp_q[$];
    vec_t vt[16];

    int n_cmp    = 0;
    int n_err    = 0;
    int hit_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Steps n cycles, sampling outputs on the falling edge and tallying pulses.
    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clock);
            if (hit)  hit_cnt++;
            if (miss) miss_cnt++;
        end
    endtask

    task automatic press(input logic [2:0] b);
        button = b;
        cycles(8);
        button = 3'b000;
        cycles(10);
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        int   s_hold;
        int   t_hold;
        e.name    = v.name;
        e.hits    = v.hits;
        e.misses  = v.misses;
        e.score   = v.score;
        e.to_hold = v.to_hold;
        e.to_end  = v.to_end;
        exp_q.push_back(e);
        hit_cnt  = 0;
        miss_cnt = 0;
        mole     = v.mole;
        press(v.btn);
        s_hold = int'(score);
        t_hold = int'(turnoff);
        mole   = v.mole_after;
        cycles(3);
        e = exp_q.pop_front();
        check({e.name, ".hits"},    hit_cnt,       e.hits);
        check({e.name, ".misses"},  miss_cnt,      e.misses);
        check({e.name, ".score"},   s_hold,        e.score);
        check({e.name, ".to_hold"}, t_hold,        e.to_hold);
        check({e.name, ".to_end"},  int'(turnoff), e.to_end);
    endtask

    initial begin
        vec_t v;

        //          name             mole    btn     after   hit mis sc  th te
        vt[0]  = '{"hit_b0",        3'b001, 3'b001, 3'b000, 1,  0,  1,  1, 0};
        vt[1]  = '{"miss_1_to_0",   3'b010, 3'b001, 3'b010, 0,  1,  0,  0, 0};
        vt[2]  = '{"miss_at_zero",  3'b010, 3'b001, 3'b000, 0,  1,  0,  0, 0};
        vt[3]  = '{"no_mole",       3'b000, 3'b001, 3'b000, 0,  0,  0,  0, 0};
        vt[4]  = '{"hit_b1",        3'b010, 3'b010, 3'b000, 1,  0,  1,  1, 0};
        vt[5]  = '{"hit_b2",        3'b100, 3'b100, 3'b000, 1,  0,  2,  1, 0};
        vt[6]  = '{"hit_b0_again",  3'b001, 3'b001, 3'b000, 1,  0,  3,  1, 0};
        vt[7]  = '{"hit_of_110",    3'b110, 3'b010, 3'b000, 1,  0,  4,  1, 0};
        vt[8]  = '{"hit_of_101",    3'b101, 3'b100, 3'b000, 1,  0,  5,  1, 0};
        vt[9]  = '{"miss_5_to_4",   3'b010, 3'b001, 3'b000, 0,  1,  4,  0, 0};
        vt[10] = '{"two_btn_hit",   3'b001, 3'b011, 3'b000, 1,  0,  5,  1, 0};
        vt[11] = '{"hit_b2_of_110", 3'b110, 3'b100, 3'b000, 1,  0,  6,  1, 0};
        vt[12] = '{"miss_of_101",   3'b101, 3'b010, 3'b000, 0,  1,  5,  0, 0};
        vt[13] = '{"hit_b1_of_011", 3'b011, 3'b110, 3'b000, 1,  0,  6,  1, 0};
        vt[14] = '{"hit_stay_held", 3'b001, 3'b001, 3'b001, 1,  0,  7,  1, 1};
        vt[15] = '{"held_ignore",   3'b001, 3'b001, 3'b001, 0,  0,  7,  1, 1};

        cycles(2);
        check("rst.score",   int'(score),   0);
        check("rst.turnoff", int'(turnoff), 0);
        check("rst.hit",     int'(hit),     0);
        check("rst.miss",    int'(miss),    0);

        resetn = 1'b1;
        game   = 1'b1;
        cycles(2);

        for (int i = 0; i < 16; i++) begin
            apply(vt[i]);
        end

        // Leaving the game from HELD with score 7 clears everything one cycle later.
        game = 1'b0;
        cycles(1);
        check("gameoff.score",   int'(score),   0);
        check("gameoff.turnoff", int'(turnoff), 0);
        game = 1'b1;
        mole = 3'b000;
        cycles(2);

        v = '{"rearm_hit", 3'b001, 3'b001, 3'b000, 1, 0, 1, 1, 0};
        apply(v);

        // Single-cycle bounces on button[2] must never reach the judge.
        hit_cnt  = 0;
        miss_cnt = 0;
        mole     = 3'b100;
        repeat (5) begin
            button = 3'b100;
            cycles(1);
            button = 3'b000;
            cycles(1);
        end
        cycles(10);
        check("bounce.hits",    hit_cnt,       0);
        check("bounce.misses",  miss_cnt,      0);
        check("bounce.score",   int'(score),   1);
        check("bounce.turnoff", int'(turnoff), 0);
        mole = 3'b000;
        cycles(2);

        repeat (254) begin
            mole = 3'b001;
            press(3'b001);
            mole = 3'b000;
            cycles(2);
        end
        check("sat.score_255", int'(score), 255);

        hit_cnt  = 0;
        miss_cnt = 0;
        mole     = 3'b001;
        press(3'b001);
        check("sat.hit_pulse", hit_cnt,       1);
        check("sat.score",     int'(score),   255);
        check("sat.turnoff",   int'(turnoff), 1);

        hit_cnt = 0;
        press(3'b001);
        check("sat_held.hits",    hit_cnt,       0);
        check("sat_held.misses",  miss_cnt,      0);
        check("sat_held.score",   int'(score),   255);
        check("sat_held.turnoff", int'(turnoff), 1);
        mole = 3'b000;
        cycles(3);
        check("sat_release.turnoff", int'(turnoff), 0);

        // Asynchronous reset while HELD must clear outputs without waiting for a clock edge.
        mole = 3'b001;
        press(3'b001);
        check("pre_rst.turnoff", int'(turnoff), 1);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst.score",   int'(score),   0);
        check("midrst.turnoff", int'(turnoff), 0);
        check("midrst.hit",     int'(hit),     0);
        check("midrst.miss",    int'(miss),    0);
        cycles(2);
        resetn = 1'b1;
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
